// File: rtl/ipnuma_cfgregs.sv
// IP-NUMA bridge configuration registers: shadow/active double-buffered
// per-channel peer addresses with atomic commit; optional IPNUMA_CFG_STATS_EN.
//
// Ports:
//   pcie_clk, sys_rst              clock, synchronous active-high reset
//   slv_bar_i/ce/we/adr/dat/sel    16-bit PCIe slave bus (word addressed)
//   slv_dat_o                      read data, valid one cycle after a read
//   commit_hold / commit_done      consumer busy / one-cycle commit pulse
//   if_v4addr, if_macaddr          active interface addresses
//   dest_v4addr, dest_macaddr,     active per-channel values, channel c at
//   mem_paddr                      slice [W*c +: W]
//   tx_pkt, rx_pkt                 per-channel packet events (stats build)
// Macro IPNUMA_CFG_STATS_EN adds 32-bit TX/RX counters per channel.
module ipnuma_cfgregs #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned BAR_IDX    = 0,
  parameter logic [47:0] MEM_BASE   = 48'h0000_d000_0000,
  parameter logic [47:0] MEM_STRIDE = 48'h0000_1000_0000
) (
  input  logic              pcie_clk,
  input  logic              sys_rst,
  input  logic [6:0]        slv_bar_i,
  input  logic              slv_ce_i,
  input  logic              slv_we_i,
  input  logic [19:1]       slv_adr_i,
  input  logic [15:0]       slv_dat_i,
  input  logic [1:0]        slv_sel_i,
  output logic [15:0]       slv_dat_o,
  input  logic              commit_hold,
  output logic              commit_done,
  output logic [31:0]       if_v4addr,
  output logic [47:0]       if_macaddr,
  output logic [32*NCH-1:0] dest_v4addr,
  output logic [48*NCH-1:0] dest_macaddr,
  output logic [48*NCH-1:0] mem_paddr,
  input  logic [NCH-1:0]    tx_pkt,
  input  logic [NCH-1:0]    rx_pkt
);

  localparam logic [31:0] IFV4_RST  = 32'h0A00_15C7;
  localparam logic [47:0] IFMAC_RST = 48'h0037_7600_0001;
  localparam logic [31:0] DV4_RST   = 32'h0A00_15FF;
  localparam logic [47:0] DMAC_RST  = 48'hFFFF_FFFF_FFFF;

  typedef enum logic {S_IDLE, S_PEND} state_e;

  function automatic logic [15:0] lane_wr(
    input logic [15:0] old,
    input logic [15:0] d,
    input logic [1:0]  s
  );
    return {s[1] ? d[15:8] : old[15:8],
            s[0] ? d[7:0]  : old[7:0]};
  endfunction

  // mem paddr words are presented with their bytes swapped on the bus
  function automatic logic [15:0] bswap(input logic [15:0] x);
    return {x[7:0], x[15:8]};
  endfunction

  function automatic logic [47:0] mem_rst(input int c);
    return MEM_BASE + MEM_STRIDE * 48'(c);
  endfunction

  logic           acc, wr, rd, glb;
  logic [8:0]     w;
  logic [3:0]     off;
  logic [4:0]     ch_idx;
  logic [NCH-1:0] ch_hit;
  logic           req, commit, pend;
  state_e         state_q, state_d;
  logic [15:0]    rd_val, rdata_q;

  logic [31:0] sh_ifv4_q, act_ifv4_q;
  logic [47:0] sh_ifmac_q, act_ifmac_q;
  logic [31:0] sh_dv4_q [NCH];
  logic [31:0] act_dv4_q [NCH];
  logic [47:0] sh_dmac_q [NCH];
  logic [47:0] act_dmac_q [NCH];
  logic [47:0] sh_mem_q [NCH];
  logic [47:0] act_mem_q [NCH];

  assign acc    = slv_bar_i[BAR_IDX] & slv_ce_i;
  assign wr     = acc & slv_we_i;
  assign rd     = acc & ~slv_we_i;
  assign w      = slv_adr_i[9:1];
  assign off    = w[3:0];
  assign glb    = (w[8:4] == 5'd0);
  assign ch_idx = w[8:4] - 5'd1;

  always_comb begin
    for (int c = 0; c < NCH; c++) begin
      ch_hit[c] = !glb && (ch_idx == 5'(c));
    end
  end

  assign pend = (state_q == S_PEND);
  assign req  = wr && (w == 9'h006) && slv_sel_i[0] && slv_dat_i[0];

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  // a request while pending is absorbed into the pending commit
  always_comb begin
    state_d = state_q;
    commit  = 1'b0;
    unique case (state_q)
      S_IDLE: if (req) state_d = S_PEND;
      S_PEND: if (!commit_hold) begin
        commit  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign commit_done = commit;

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      sh_ifv4_q  <= IFV4_RST;
      sh_ifmac_q <= IFMAC_RST;
      for (int c = 0; c < NCH; c++) begin
        sh_dv4_q[c]  <= DV4_RST;
        sh_dmac_q[c] <= DMAC_RST;
        sh_mem_q[c]  <= mem_rst(c);
      end
    end else if (wr) begin
      if (glb) begin
        unique case (off)
          4'h0: sh_ifv4_q[31:16] <=
                  lane_wr(sh_ifv4_q[31:16], slv_dat_i, slv_sel_i);
          4'h1: sh_ifv4_q[15:0] <=
                  lane_wr(sh_ifv4_q[15:0], slv_dat_i, slv_sel_i);
          4'h2: sh_ifmac_q[47:32] <=
                  lane_wr(sh_ifmac_q[47:32], slv_dat_i, slv_sel_i);
          4'h3: sh_ifmac_q[31:16] <=
                  lane_wr(sh_ifmac_q[31:16], slv_dat_i, slv_sel_i);
          4'h4: sh_ifmac_q[15:0] <=
                  lane_wr(sh_ifmac_q[15:0], slv_dat_i, slv_sel_i);
          default: ;
        endcase
      end
      for (int c = 0; c < NCH; c++) begin
        if (ch_hit[c]) begin
          unique case (off)
            4'h0: sh_dv4_q[c][31:16] <=
                    lane_wr(sh_dv4_q[c][31:16], slv_dat_i, slv_sel_i);
            4'h1: sh_dv4_q[c][15:0] <=
                    lane_wr(sh_dv4_q[c][15:0], slv_dat_i, slv_sel_i);
            4'h2: sh_dmac_q[c][47:32] <=
                    lane_wr(sh_dmac_q[c][47:32], slv_dat_i, slv_sel_i);
            4'h3: sh_dmac_q[c][31:16] <=
                    lane_wr(sh_dmac_q[c][31:16], slv_dat_i, slv_sel_i);
            4'h4: sh_dmac_q[c][15:0] <=
                    lane_wr(sh_dmac_q[c][15:0], slv_dat_i, slv_sel_i);
            4'h5: sh_mem_q[c][15:0] <= bswap(
                    lane_wr(bswap(sh_mem_q[c][15:0]), slv_dat_i, slv_sel_i));
            4'h6: sh_mem_q[c][31:16] <= bswap(
                    lane_wr(bswap(sh_mem_q[c][31:16]), slv_dat_i, slv_sel_i));
            4'h7: sh_mem_q[c][47:32] <= bswap(
                    lane_wr(bswap(sh_mem_q[c][47:32]), slv_dat_i, slv_sel_i));
            default: ;
          endcase
        end
      end
    end
  end

  // copies the pre-edge shadow, so a write in the commit cycle stays shadow-only
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      act_ifv4_q  <= IFV4_RST;
      act_ifmac_q <= IFMAC_RST;
      for (int c = 0; c < NCH; c++) begin
        act_dv4_q[c]  <= DV4_RST;
        act_dmac_q[c] <= DMAC_RST;
        act_mem_q[c]  <= mem_rst(c);
      end
    end else if (commit) begin
      act_ifv4_q  <= sh_ifv4_q;
      act_ifmac_q <= sh_ifmac_q;
      for (int c = 0; c < NCH; c++) begin
        act_dv4_q[c]  <= sh_dv4_q[c];
        act_dmac_q[c] <= sh_dmac_q[c];
        act_mem_q[c]  <= sh_mem_q[c];
      end
    end
  end

  assign if_v4addr  = act_ifv4_q;
  assign if_macaddr = act_ifmac_q;

  for (genvar c = 0; c < NCH; c++) begin : g_out
    assign dest_v4addr[32*c +: 32]  = act_dv4_q[c];
    assign dest_macaddr[48*c +: 48] = act_dmac_q[c];
    assign mem_paddr[48*c +: 48]    = act_mem_q[c];
  end

`ifdef IPNUMA_CFG_STATS_EN
  logic [31:0] cnt_q  [NCH][2];
  logic [15:0] snap_q [NCH][2];
  logic        snv_q  [NCH][2];

  function automatic logic [3:0] hi_off(input int k);
    return (k == 0) ? 4'h8 : 4'hA;
  endfunction

  // hi read snapshots lo so a hi/lo pair reads one coherent 32-bit value
  always_ff @(posedge pcie_clk) begin
    if (sys_rst) begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < 2; k++) begin
          cnt_q[c][k]  <= '0;
          snap_q[c][k] <= '0;
          snv_q[c][k]  <= 1'b0;
        end
      end
    end else begin
      for (int c = 0; c < NCH; c++) begin
        for (int k = 0; k < 2; k++) begin
          if (wr && ch_hit[c] && off == hi_off(k))
            cnt_q[c][k] <= '0;
          else if ((k == 0) ? tx_pkt[c] : rx_pkt[c])
            cnt_q[c][k] <= cnt_q[c][k] + 32'd1;
          if (rd && ch_hit[c] && off == hi_off(k)) begin
            snap_q[c][k] <= cnt_q[c][k][15:0];
            snv_q[c][k]  <= 1'b1;
          end else if (rd && ch_hit[c] && off == hi_off(k) + 4'd1) begin
            snv_q[c][k]  <= 1'b0;
          end
        end
      end
    end
  end

  logic unused_ok;
  assign unused_ok = ^{slv_adr_i[19:10], slv_bar_i};
`else
  logic unused_ok;
  assign unused_ok = ^{slv_adr_i[19:10], slv_bar_i, tx_pkt, rx_pkt};
`endif

  always_comb begin
    rd_val = '0;
    if (glb) begin
      unique case (off)
        4'h0: rd_val = sh_ifv4_q[31:16];
        4'h1: rd_val = sh_ifv4_q[15:0];
        4'h2: rd_val = sh_ifmac_q[47:32];
        4'h3: rd_val = sh_ifmac_q[31:16];
        4'h4: rd_val = sh_ifmac_q[15:0];
        4'h6: rd_val = {15'b0, pend};
        4'h7: rd_val = {8'(NCH), 7'b0, pend};
        default: rd_val = '0;
      endcase
    end
    for (int c = 0; c < NCH; c++) begin
      if (ch_hit[c]) begin
        unique case (off)
          4'h0: rd_val = sh_dv4_q[c][31:16];
          4'h1: rd_val = sh_dv4_q[c][15:0];
          4'h2: rd_val = sh_dmac_q[c][47:32];
          4'h3: rd_val = sh_dmac_q[c][31:16];
          4'h4: rd_val = sh_dmac_q[c][15:0];
          4'h5: rd_val = bswap(sh_mem_q[c][15:0]);
          4'h6: rd_val = bswap(sh_mem_q[c][31:16]);
          4'h7: rd_val = bswap(sh_mem_q[c][47:32]);
`ifdef IPNUMA_CFG_STATS_EN
          4'h8: rd_val = cnt_q[c][0][31:16];
          4'h9: rd_val = snv_q[c][0] ? snap_q[c][0] : cnt_q[c][0][15:0];
          4'hA: rd_val = cnt_q[c][1][31:16];
          4'hB: rd_val = snv_q[c][1] ? snap_q[c][1] : cnt_q[c][1][15:0];
`endif
          default: rd_val = '0;
        endcase
      end
    end
  end

  always_ff @(posedge pcie_clk) begin
    if (sys_rst) rdata_q <= '0;
    else if (rd) rdata_q <= rd_val;
  end

  assign slv_dat_o = slv_bar_i[BAR_IDX] ? rdata_q : 16'h0;

endmodule

// File: tb/tb_ipnuma_cfgregs.sv
// Directed bench for ipnuma_cfgregs: read replies go through a
// scoreboard queue; active outputs are checked directly.
module tb_ipnuma_cfgregs;

`ifdef IPNUMA_CFG_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [6:0]   bar;
  logic         ce, we;
  logic [19:1]  adr;
  logic [15:0]  dat;
  logic [1:0]   sel;
  logic [15:0]  dout;
  logic         hold, done;
  logic [31:0]  ifv4;
  logic [47:0]  ifmac;
  logic [127:0] dv4;
  logic [191:0] dmac, mem;
  logic [3:0]   tx, rx;

  typedef struct {
    string       tag;
    logic [15:0] exp;
  } sb_t;

  sb_t sb_q[$];
  int  checks = 0;
  int  errors = 0;

  always #5 clk = ~clk;

  ipnuma_cfgregs dut (
    .pcie_clk     (clk),
    .sys_rst      (rst),
    .slv_bar_i    (bar),
    .slv_ce_i     (ce),
    .slv_we_i     (we),
    .slv_adr_i    (adr),
    .slv_dat_i    (dat),
    .slv_sel_i    (sel),
    .slv_dat_o    (dout),
    .commit_hold  (hold),
    .commit_done  (done),
    .if_v4addr    (ifv4),
    .if_macaddr   (ifmac),
    .dest_v4addr  (dv4),
    .dest_macaddr (dmac),
    .mem_paddr    (mem),
    .tx_pkt       (tx),
    .rx_pkt       (rx)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [8:0] w, input logic [15:0] d,
                    input logic [1:0] s);
    @(negedge clk);
    bar = 7'h01; ce = 1'b1; we = 1'b1;
    adr = {10'b0, w}; dat = d; sel = s;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [8:0] w,
                    input logic [15:0] e);
    sb_t s;
    sb_q.push_back('{tag, e});
    @(negedge clk);
    bar = 7'h01; ce = 1'b1; we = 1'b0;
    adr = {10'b0, w}; sel = 2'b11;
    @(posedge clk); #1;
    ce = 1'b0;
    s = sb_q.pop_front();
    chk(s.tag, 64'(dout), 64'(s.exp));
  endtask

  initial begin
    rst = 1'b1; bar = 7'h01; ce = 1'b0; we = 1'b0;
    adr = '0; dat = '0; sel = '0; hold = 1'b0; tx = '0; rx = '0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b0;
    #1;
    chk("rst_dout", 64'(dout), 64'h0);
    chk("rst_done", 64'(done), 64'h0);
    chk("rst_ifv4", 64'(ifv4), 64'h0A00_15C7);
    chk("rst_ifmac", 64'(ifmac), 64'h0037_7600_0001);
    chk("rst_dv4_1", 64'(dv4[63:32]), 64'h0A00_15FF);
    chk("rst_dmac_0", 64'(dmac[47:0]), 64'hFFFF_FFFF_FFFF);
    chk("rst_mem_0", 64'(mem[47:0]), 64'hD000_0000);
    chk("rst_mem_3", 64'(mem[191:144]), 64'h1_0000_0000);

    rd("rd_ifv4_hi", 9'h000, 16'h0A00);
    rd("rd_ifv4_lo", 9'h001, 16'h15C7);
    rd("rd_mem1_w0", 9'h025, 16'h0000);
    rd("rd_mem1_w1", 9'h026, 16'h00E0);
    rd("rd_mem1_w2", 9'h027, 16'h0000);

    wr(9'h012, 16'h0011, 2'b11);
    wr(9'h013, 16'h2233, 2'b11);
    wr(9'h014, 16'h4455, 2'b11);
    wr(9'h026, 16'hAB12, 2'b11);
    rd("rd_mem1_sh", 9'h026, 16'hAB12);
    chk("dmac_pre", 64'(dmac[47:0]), 64'hFFFF_FFFF_FFFF);
    chk("mem1_pre", 64'(mem[95:48]), 64'hE000_0000);

    wr(9'h006, 16'h0001, 2'b11);
    chk("done_pulse", 64'(done), 64'h1);
    chk("dmac_cyc", 64'(dmac[47:0]), 64'hFFFF_FFFF_FFFF);
    @(posedge clk); #1;
    chk("dmac_commit", 64'(dmac[47:0]), 64'h0011_2233_4455);
    chk("mem1_commit", 64'(mem[95:48]), 64'h0000_12AB_0000);
    chk("done_end", 64'(done), 64'h0);

    wr(9'h001, 16'h0403, 2'b01);
    rd("rd_lane0", 9'h001, 16'h1503);
    chk("ifv4_nocommit", 64'(ifv4), 64'h0A00_15C7);

    hold = 1'b1;
    wr(9'h006, 16'h0001, 2'b11);
    rd("status_pend", 9'h007, 16'h0401);
    rd("ctrl_pend", 9'h006, 16'h0001);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_ifv4", 64'(ifv4), 64'h0A00_15C7);
      chk("hold_done", 64'(done), 64'h0);
    end
    @(negedge clk); hold = 1'b0;
    #1;
    chk("release_done", 64'(done), 64'h1);
    @(posedge clk); #1;
    chk("release_ifv4", 64'(ifv4), 64'h0A00_1503);
    rd("status_idle", 9'h007, 16'h0400);

    @(negedge clk);
    bar = 7'h00; ce = 1'b1; we = 1'b1;
    adr = {10'b0, 9'h001}; dat = 16'hFFFF; sel = 2'b11;
    @(posedge clk); #1;
    chk("nobar_dout", 64'(dout), 64'h0);
    ce = 1'b0; we = 1'b0;
    rd("nobar_keep", 9'h001, 16'h1503);

    wr(9'h050, 16'h1234, 2'b11);
    rd("rd_ch4", 9'h050, 16'h0000);
    wr(9'h040, 16'hC0A8, 2'b11);
    rd("rd_ch3", 9'h040, 16'hC0A8);

    for (int i = 0; i < 5; i++) begin
      @(negedge clk); tx = 4'b0100;
      @(negedge clk); tx = 4'b0000;
    end
    rd("tx2_hi", 9'h038, 16'h0000);
    @(negedge clk); tx = 4'b0100;
    @(negedge clk); tx = 4'b0000;
    rd("tx2_snap", 9'h039, STATS ? 16'd5 : 16'd0);
    rd("tx2_live", 9'h039, STATS ? 16'd6 : 16'd0);
    rd("rx2_lo", 9'h03B, 16'h0000);

    @(negedge clk);
    bar = 7'h01; ce = 1'b1; we = 1'b1;
    adr = {10'b0, 9'h038}; dat = 16'h0; sel = 2'b11; tx = 4'b0100;
    @(posedge clk); #1;
    ce = 1'b0; we = 1'b0; tx = 4'b0000;
    rd("tx2_clr", 9'h039, 16'h0000);

    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ipnuma_cfgregs.md
Name: ipnuma_cfgregs

Overview:
- Parametrised configuration register file for the IP-NUMA bridge, on the 16-bit PCIe slave bus inside one BAR.
- Generalises the single-peer register set to NCH peer channels, each with dest IPv4, dest MAC and mem physical base.
- Adds shadow/active double buffering with an atomic commit handshake, so the requester never sees a torn 48-bit address.
- Optional per-channel TX/RX packet counters; active values feed requester/server.

Parameters:
NCH, 4, number of peer channels (1..16)
BAR_IDX, 0, slv_bar_i bit that selects this block
MEM_BASE, 48'h0000_d0000000, reset mem paddr of channel 0
MEM_STRIDE, 48'h0000_10000000, reset paddr increment per channel

Ports:
pcie_clk  in  1  clock; all logic on rising edge
sys_rst  in  1  synchronous active-high reset
slv_bar_i  in  7  BAR hit vector
slv_ce_i  in  1  bus cycle enable
slv_we_i  in  1  1=write, 0=read
slv_adr_i  in  19  word address [19:1]; only [9:1] decoded
slv_dat_i  in  16  write data
slv_sel_i  in  2  byte lane enables ([0]=dat[7:0], [1]=dat[15:8])
slv_dat_o  out  16  read data
commit_hold  in  1  1=consumer busy, commit must wait
commit_done  out  1  one-cycle pulse when shadow copied to active
if_v4addr  out  32  active interface IPv4
if_macaddr  out  48  active interface MAC
dest_v4addr  out  32*NCH  active dest IPv4, channel c at [32c+31:32c]
dest_macaddr  out  48*NCH  active dest MAC, packed likewise
mem_paddr  out  48*NCH  active mem physical base, packed likewise
tx_pkt  in  NCH  per-channel TX packet event pulse
rx_pkt  in  NCH  per-channel RX packet event pulse

Behaviour:
- Access = slv_bar_i[BAR_IDX] & slv_ce_i. W = word address slv_adr_i[9:1].
- Global map: 0x000/0x001 if_v4addr [31:16]/[15:0]; 0x002/0x003/0x004 if_macaddr [47:32]/[31:16]/[15:0]; 0x006 CTRL; 0x007 STATUS.
- Channel c base B = 0x010 + 0x10*c:
  - B+0/B+1 dest_v4addr.
  - B+2..B+4 dest_macaddr.
  - B+5/B+6/B+7 mem_paddr [15:0]/[31:16]/[47:32], byte-swapped: lane0 = upper byte of field, lane1 = lower byte.
  - B+8/B+9 TX count hi/lo; B+A/B+B RX count hi/lo.
- Channels >= NCH and unmapped words: writes ignored, reads return 0.
- Writes go to the shadow copy, per byte lane per slv_sel_i. Reads return the shadow copy.
- Read latency 1 cycle: internal rdata_q updates on the edge after a read access and holds otherwise. slv_dat_o = rdata_q when slv_bar_i[BAR_IDX], else 0.
- CTRL write with sel[0] and dat[0]=1 sets commit_pend. Writing 0 has no effect. CTRL reads as {15'b0, commit_pend}.
- STATUS reads {NCH[7:0], 7'b0, commit_pend}.
- Commit state machine:
  - IDLE -> PEND on request.
  - PEND -> IDLE on the first cycle with commit_hold=0: all shadow copied to active, commit_done=1 that cycle, pend cleared.
  - A request while in PEND is absorbed.
  - A shadow write in the commit cycle: the new write lands in shadow only and is not committed.
- Active outputs change only in the commit cycle.
- Reset (also mid-PEND):
  - if_v4addr 10.0.21.199, if_macaddr 48'h003776_000001.
  - Each channel: dest 10.0.21.255, MAC ffff_ffff_ffff, mem MEM_BASE + c*MEM_STRIDE (48-bit wrap).
  - Shadow = active; pend=0; commit_done=0; rdata_q=0; counters 0.

Optional Feature:
- Macro IPNUMA_CFG_STATS_EN.
- Defined:
  - 32-bit wrapping TX/RX counters per channel, incremented on tx_pkt[c]/rx_pkt[c].
  - Reading the hi word latches the lo word into a snapshot; the following lo read returns the snapshot. A lo read without a preceding hi read returns the live value.
  - Any write to the hi word clears the counter. Clear and event in the same cycle -> 0 (clear wins).
- Undefined: counter words read 0, tx_pkt/rx_pkt are ignored, and no counter logic is generated.

Test Plan:
- Reset, read 0x000, 0x001 and channel 1 B+5..B+7 -> 0x0A00, 0x15C7, then the mem paddr reset value for channel 1 in byte-swapped lane order; each reply valid one cycle after the access.
- Write ch0 dest MAC words 0x012=0x0011, 0x013=0x2233, 0x014=0x4455 -> dest_macaddr[47:0] stays ffff_ffff_ffff. Write CTRL=1 with commit_hold=0 -> next cycle dest_macaddr[47:0]=0x0011_2233_4455 and commit_done pulses once.
- commit_hold=1, CTRL=1 -> STATUS bit0=1 and outputs unchanged for 10 cycles; drop hold -> commit that cycle, STATUS bit0=0.
- Write 0x0403 with sel=2'b01 to word 0x001 -> if_v4addr shadow [15:0]=0x1503 (only the low lane changes).
- With STATS_EN: 5 tx_pkt pulses on ch2, read 0x038 then 0x039 -> 0x0000, 0x0005. Write 0x038 in the same cycle as a tx_pkt -> count 0.
- Access with slv_bar_i[BAR_IDX]=0, or to word 0x050 with NCH=4 -> no state change; slv_dat_o=0.
